msc16_uart_tx: RTL



---
 rtl/msc16_pkg.sv | 22 ++
 rtl/msc16_sync_fifo.sv | 59 +++++
 rtl/msc16_uart_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/msc16_pkg.sv
// Shared constants for the msc16 UART transmitter:
// register offsets, STATUS bit positions and FSM states.
package msc16_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/msc16_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap for free.
module msc16_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msc16_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the msc16 bus:
// DATA/STATUS/DIV registers, byte FIFO and serialiser.
module msc16_uart_tx
    import msc16_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] rd_data,
    output logic        rd_sel,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic          wr;
    logic          rd;
    logic [1:0]    off;
    logic          addr_unused;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_q;
    logic [CW-1:0] count;
    logic [15:0]   div;
    logic [15:0]   bit_div;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          ovf;
    logic          bit_end;
    logic          tx_d;
    logic [15:0]   status;
    logic [15:0]   rd_mux;
    tx_state_t     state;
    tx_state_t     state_d;

    assign hit         = mem_en && (mem_addr[15:3] == BASE_ADDR[15:3]);
    assign off         = mem_addr[2:1];
    assign wr          = hit && mem_we;
    assign rd          = hit && !mem_we;
    assign push        = wr && (off == REG_DATA);
    assign addr_unused = mem_addr[0];
    assign bit_end     = (cnt == bit_div);

    msc16_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (mem_wdata[7:0]),
        .pop   (pop),
        .rdata (fifo_q),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        status                = '0;
        status[ST_FULL]       = full;
        status[ST_EMPTY]      = empty;
        status[ST_BUSY]       = (state != S_IDLE);
        status[ST_OVF]        = ovf;
        status[ST_CNT +: CW]  = count;
        rd_mux                = '0;
        case (off)
            REG_STATUS: rd_mux = status;
            REG_DIV:    rd_mux = div;
            default:    rd_mux = '0;
        endcase
    end

    // A push to a full FIFO is lost even if the serialiser pops that cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_sel  <= 1'b0;
            rd_data <= '0;
            div     <= DIV_RESET;
            ovf     <= 1'b0;
        end else begin
            rd_sel  <= rd;
            rd_data <= rd ? rd_mux : '0;
            if (wr && (off == REG_DIV)) begin
                div <= mem_wdata;
            end
            if (push && full) begin
                ovf <= 1'b1;
            end else if (rd && (off == REG_STATUS)) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                tx_d = shift[0];
                if (bit_end && (bit_idx == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // tx is registered, so the line lags the state by one clock.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            bit_div <= '0;
        end else begin
            tx <= tx_d;
            if (pop) begin
                shift   <= fifo_q;
                bit_div <= div;
                cnt     <= '0;
                bit_idx <= '0;
            end else if (state != S_IDLE) begin
                if (bit_end) begin
                    cnt <= '0;
                    if (state == S_DATA) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

endmodule
